sdpram_rd_stream: RTL and testbench
===================================

Name: sdpram_rd_stream

Overview:
- Read-side sequencer for the 12-bit x 8-bit simple dual-port RAM (drm_data). Sits directly downstream of the RAM read port.
- Accepts a burst command (start address, length) and drives the RAM read address. Tracks the fixed RAM read latency.
- Returns the data as a valid/ready stream, with full backpressure through a small credit-controlled output FIFO.
- Runs in the read clock domain only.

Parameters:
- ADDR_WIDTH, 12, RAM address width; burst addresses wrap modulo 2**ADDR_WIDTH.
- DATA_WIDTH, 8, RAM/stream data width.
- RD_LATENCY, 2, RAM address-to-data latency in cycles: 2 with OUTPUT_REG=1, 1 without. Legal values are 1 and 2.
- FIFO_DEPTH, 4, output FIFO entries. Power of 2, at least RD_LATENCY+2.

Ports:
- rd_clk  in  1  clock; all logic on its rising edge.
- rd_rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  burst command valid.
- cmd_ready  out  1  command accepted when cmd_valid && cmd_ready.
- cmd_addr  in  ADDR_WIDTH  burst start address.
- cmd_len  in  ADDR_WIDTH+1  burst length in words, 1..2**ADDR_WIDTH.
- ram_rd_addr  out  ADDR_WIDTH  to RAM rd_addr.
- ram_rd_data  in  DATA_WIDTH  from RAM rd_data.
- m_valid  out  1  stream data valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_WIDTH  stream data.
- m_last  out  1  final word of the burst.
- busy  out  1  high from command accept until the last word is accepted downstream.

Behaviour:
- Reset values: cmd_ready=0 during reset, 1 in the first cycle after. ram_rd_addr=0, m_valid=0, m_data=0, m_last=0, busy=0. FIFO is emptied, in-flight pipe is cleared, state=IDLE.
- States:
  - IDLE: cmd_ready=1. An accepted command with cmd_len!=0 loads addr=cmd_addr and remaining=cmd_len, then moves to ISSUE.
  - An accepted command with cmd_len==0 is dropped: no reads, no output, state stays IDLE.
  - ISSUE: a read is issued in any cycle where occupancy + inflight + (pop? -1:0) < FIFO_DEPTH. On issue: ram_rd_addr<=addr, addr<=addr+1 (wraps 0xFFF->0x000), remaining-=1. When the last read issues, go to DRAIN.
  - DRAIN: wait until the FIFO is empty and inflight==0, then return to IDLE. cmd_ready=0 in ISSUE and DRAIN.
- The RAM has no read enable; it reads every cycle. Validity travels in a RD_LATENCY-deep shift register, tagged with last = (remaining==1 at issue).
- RAM data is written into the FIFO exactly RD_LATENCY cycles after ram_rd_addr is registered. When the read is registered at edge N, push happens at edge N+RD_LATENCY+... rule: data sampled on the edge where the valid tag exits the pipe.
- ram_rd_addr holds its value when no read issues.
- Credit rule guarantees the FIFO never overflows; a push into a full FIFO is a design error.
- FIFO is first-word-fall-through: m_valid = !empty; m_data and m_last come from the head entry.
- Pop on m_valid && m_ready. Push and pop in the same cycle leave occupancy unchanged.
- Latency: with m_ready held 1, the command accept edge is at t. The first ram_rd_addr update is at t+1, and the first m_valid is at t+1+RD_LATENCY (t+3 by default).
- Throughput: 1 word/cycle with m_ready held 1 and FIFO_DEPTH >= RD_LATENCY+2.
- Data is presented in address order. m_last is asserted on exactly one word per burst.
- busy = (state!=IDLE).
- Reset asserted mid-burst: everything returns to reset values at the next edge. Outstanding RAM reads are discarded and produce no output.
- m_valid, m_data and m_last stay stable while m_valid && !m_ready.

Optional Feature:
- Macro: RD_STREAM_STATS_EN.
- Defined: adds output stall_cnt [15:0]. It counts cycles with m_valid && !m_ready, saturates at 0xFFFF, and clears on rd_rst and on each command accept.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Writer pre-fills RAM[a] = ~a[7:0]. Command addr=0x000, len=16, m_ready=1 -> 16 words 0xFF,0xFE,..0xF0 on consecutive cycles. First m_valid 3 cycles after accept; m_last only on 0xF0; busy drops the cycle after the last pop.
- Wrap: addr=0xFFE, len=4 -> ram_rd_addr sequence 0xFFE,0xFFF,0x000,0x001. Data 0x01,0x00,0xFF,0xFE.
- Backpressure: len=32, m_ready toggles 1-cycle-on/2-cycles-off -> no word lost or duplicated, FIFO occupancy never exceeds 4. Data is held stable while stalled. With RD_STREAM_STATS_EN, stall_cnt=62 at completion.
- cmd_len=0 -> no reads issued, m_valid stays 0, cmd_ready stays 1. Next command with len=1 at 0x010 -> single word 0xEF with m_last=1.
- Full-depth burst: addr=0x000, len=4096, m_ready=1 -> 4096 words, last = 0x00 at address 0xFFF. cmd_ready=0 throughout.
- Reset mid-burst after 5 words popped of a len=20 burst -> the cycle after rd_rst, m_valid=0, busy=0, cmd_ready=1, and no stale words appear. A new burst then returns correct data.

Source files
------------

// File: rtl/sdpram_rd_stream.sv
// sdpram_rd_stream: burst read sequencer for the 12x8 SDP RAM, returns data as a valid/ready stream via a credit-checked FWFT FIFO.
// Optional stall counter output stall_cnt enabled by defining RD_STREAM_STATS_EN.
module sdpram_rd_stream #(
   parameter int ADDR_WIDTH = 12,
   parameter int DATA_WIDTH = 8,
   parameter int RD_LATENCY = 2,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                  rd_clk,
   input  logic                  rd_rst,
   input  logic                  cmd_valid,
   output logic                  cmd_ready,
   input  logic [ADDR_WIDTH-1:0] cmd_addr,
   input  logic [ADDR_WIDTH:0]   cmd_len,
   output logic [ADDR_WIDTH-1:0] ram_rd_addr,
   input  logic [DATA_WIDTH-1:0] ram_rd_data,
   output logic                  m_valid,
   input  logic                  m_ready,
   output logic [DATA_WIDTH-1:0] m_data,
   output logic                  m_last,
`ifdef RD_STREAM_STATS_EN
   output logic [15:0]           stall_cnt,
`endif
   output logic                  busy
);
   localparam int PW = $clog2(FIFO_DEPTH);
   localparam logic [1:0] IDLE = 2'd0, ISSUE = 2'd1, DRAIN = 2'd2;
   logic [1:0] state_q, state_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d, rd_addr_q, rd_addr_d;
   logic [ADDR_WIDTH:0] rem_q, rem_d;
   logic [RD_LATENCY-1:0] vld_q, lst_q;
   logic [DATA_WIDTH-1:0] dat_mem [FIFO_DEPTH];
   logic lst_mem [FIFO_DEPTH];
   logic [PW-1:0] wr_q, rd_q;
   logic [PW:0] cnt_q, cnt_d, inflight;
   logic accept, issue, push, pop, last_issue;
   assign cmd_ready   = (state_q == IDLE) && !rd_rst;
   assign accept      = cmd_valid && cmd_ready;
   assign push        = vld_q[RD_LATENCY-1];
   assign m_valid     = cnt_q != '0;
   assign pop         = m_valid && m_ready;
   assign last_issue  = rem_q == (ADDR_WIDTH+1)'(1);
   assign m_data      = m_valid ? dat_mem[rd_q] : '0;
   assign m_last      = m_valid && lst_mem[rd_q];
   assign busy        = state_q != IDLE;
   assign ram_rd_addr = rd_addr_q;
   assign cnt_d       = cnt_q + (PW+1)'(push) - (PW+1)'(pop);
   always_comb begin
      inflight = '0;
      for (int i = 0; i < RD_LATENCY; i++) inflight = inflight + (PW+1)'(vld_q[i]);
   end
   // Reads already in the RAM pipe hold a FIFO slot, so the FIFO can never overflow.
   assign issue = (state_q == ISSUE) && (int'(cnt_q) + int'(inflight) - int'(pop) < FIFO_DEPTH);
   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      rd_addr_d = rd_addr_q;
      if (accept && cmd_len != '0) begin
         state_d = ISSUE;
         addr_d  = cmd_addr;
         rem_d   = cmd_len;
      end
      if (issue) begin
         rd_addr_d = addr_q;
         addr_d    = addr_q + ADDR_WIDTH'(1);
         rem_d     = rem_q - (ADDR_WIDTH+1)'(1);
         state_d   = last_issue ? DRAIN : ISSUE;
      end
      if (state_q == DRAIN && inflight == '0 && cnt_d == '0) state_d = IDLE;
   end
   always_ff @(posedge rd_clk) begin
      if (rd_rst) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         rem_q     <= '0;
         rd_addr_q <= '0;
         vld_q     <= '0;
         lst_q     <= '0;
         wr_q      <= '0;
         rd_q      <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rem_q     <= rem_d;
         rd_addr_q <= rd_addr_d;
         vld_q     <= (vld_q << 1) | RD_LATENCY'(issue);
         lst_q     <= (lst_q << 1) | RD_LATENCY'(issue && last_issue);
         wr_q      <= wr_q + PW'(push);
         rd_q      <= rd_q + PW'(pop);
         cnt_q     <= cnt_d;
      end
   end
   always_ff @(posedge rd_clk) begin
      if (push) begin
         dat_mem[wr_q] <= ram_rd_data;
         lst_mem[wr_q] <= lst_q[RD_LATENCY-1];
      end
   end
`ifdef RD_STREAM_STATS_EN
   logic [15:0] stall_q;
   always_ff @(posedge rd_clk) begin
      if (rd_rst || accept) stall_q <= '0;
      else if (m_valid && !m_ready && stall_q != 16'hFFFF) stall_q <= stall_q + 16'd1;
   end
   assign stall_cnt = stall_q;
`endif
endmodule

// File: tb/tb_sdpram_rd_stream.sv
// tb_sdpram_rd_stream: scoreboard bench for sdpram_rd_stream against a RAM holding ~addr[7:0].
module tb_sdpram_rd_stream;
   logic clk = 0, rst = 1, cmd_valid = 0, m_ready = 1;
   logic [11:0] cmd_addr = 0, ram_rd_addr;
   logic [12:0] cmd_len = 0;
   logic [7:0] ram_rd_data, m_data;
   logic cmd_ready, m_valid, m_last, busy;
`ifdef RD_STREAM_STATS_EN
   logic [15:0] stall_cnt;
`endif
   logic [7:0] mem [4096];
   logic [8:0] exp_q [$];
   int total = 0, bad = 0, pop_n = 0, stalls = 0, bp = 0, ph = 0;

   always #5 clk = ~clk;

   sdpram_rd_stream dut (
      .rd_clk(clk), .rd_rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
      .cmd_addr(cmd_addr), .cmd_len(cmd_len), .ram_rd_addr(ram_rd_addr),
      .ram_rd_data(ram_rd_data), .m_valid(m_valid), .m_ready(m_ready),
      .m_data(m_data), .m_last(m_last),
`ifdef RD_STREAM_STATS_EN
      .stall_cnt(stall_cnt),
`endif
      .busy(busy)
   );

   // Two-cycle RAM: address registered by the DUT, data registered here.
   always @(posedge clk) ram_rd_data <= mem[ram_rd_addr];

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic send(input logic [11:0] a, input logic [12:0] l);
      int n = 0;
      logic [11:0] a2;
      while (!cmd_ready && n < 10000) begin
         @(posedge clk); #1; n++;
      end
      if (n >= 10000) chk("cmd_timeout", 0, 1);
      cmd_valid = 1; cmd_addr = a; cmd_len = l;
      for (int i = 0; i < int'(l); i++) begin
         a2 = a + 12'(i);
         exp_q.push_back({i == int'(l) - 1, ~a2[7:0]});
      end
      @(posedge clk);
      stalls = 0;
      #1 cmd_valid = 0;
   endtask

   task automatic wait_idle();
      int n = 0;
      do begin
         @(negedge clk); n++;
      end while ((busy || exp_q.size() != 0) && n < 20000);
      if (n >= 20000) chk("idle_timeout", 0, 1);
   endtask

   initial begin
      forever begin
         @(posedge clk); #1;
         m_ready = (bp != 0) ? (ph == 0) : 1'b1;
         ph = (ph + 1) % 3;
      end
   end

   initial begin
      logic prev_stall = 0, prev_last = 0, last_pop = 0;
      logic [7:0] prev_data = 0;
      logic [8:0] e;
      forever begin
         @(negedge clk);
         if (rst) begin
            prev_stall = 0; last_pop = 0;
         end else begin
            if (last_pop) chk("busy_drop", 32'(busy), 0);
            if (busy) chk("rdy_busy", 32'(cmd_ready), 0);
            if (prev_stall) chk("hold", 32'({m_valid, m_last, m_data}), 32'({1'b1, prev_last, prev_data}));
            chk("occ", 32'(dut.cnt_q <= 4), 1);
            last_pop = 0;
            if (m_valid && m_ready) begin
               if (exp_q.size() == 0) chk("extra", 32'({m_last, m_data}), 32'h1ff);
               else begin
                  e = exp_q.pop_front();
                  chk("data", 32'(m_data), 32'(e[7:0]));
                  chk("last", 32'(m_last), 32'(e[8]));
                  if (e[8]) chk("busy_last", 32'(busy), 1);
                  last_pop = m_last;
               end
               pop_n++;
            end
            if (m_valid && !m_ready) stalls++;
            prev_stall = m_valid && !m_ready; prev_data = m_data; prev_last = m_last;
         end
      end
   end

   initial begin
      logic [11:0] wa [4] = '{12'hFFE, 12'hFFF, 12'h000, 12'h001};
      logic [11:0] hold_addr;
      int n;
      for (int i = 0; i < 4096; i++) mem[i] = ~8'(i);
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_rdy", 32'(cmd_ready), 0);
      chk("rst_out", 32'({m_valid, m_last, m_data, busy}), 0);
      chk("rst_addr", 32'(ram_rd_addr), 0);
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      chk("post_rst_rdy", 32'(cmd_ready), 1);
      chk("post_rst_valid", 32'(m_valid), 0);
      // Basic burst with latency and back-to-back checks.
      send(12'h000, 13'd16);
      @(negedge clk);
      chk("lat0_valid", 32'(m_valid), 0);
      chk("lat0_busy", 32'(busy), 1);
      @(negedge clk);
      chk("lat1_addr", 32'(ram_rd_addr), 0);
      chk("lat1_valid", 32'(m_valid), 0);
      @(negedge clk);
      chk("lat2_valid", 32'(m_valid), 0);
      @(negedge clk);
      chk("lat3_valid", 32'(m_valid), 1);
      for (int i = 0; i < 15; i++) begin
         @(negedge clk);
         chk("stream", 32'(m_valid), 1);
      end
      wait_idle();
      // Address wrap.
      send(12'hFFE, 13'd4);
      @(negedge clk);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("wrap_addr", 32'(ram_rd_addr), 32'(wa[i]));
      end
      wait_idle();
      // Backpressure.
      bp = 1;
      send(12'h200, 13'd32);
      wait_idle();
`ifdef RD_STREAM_STATS_EN
      chk("stall_cnt", 32'(stall_cnt), 32'(stalls));
`endif
      bp = 0;
      // Zero-length command is dropped.
      repeat (2) @(posedge clk);
      #1 hold_addr = ram_rd_addr;
      send(12'h123, 13'd0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("len0_valid", 32'(m_valid), 0);
         chk("len0_rdy", 32'(cmd_ready), 1);
         chk("len0_addr", 32'(ram_rd_addr), 32'(hold_addr));
      end
      send(12'h010, 13'd1);
      wait_idle();
      // Full address space.
      send(12'h000, 13'd4096);
      wait_idle();
      // Reset in the middle of a burst.
      @(posedge clk); #1 pop_n = 0;
      send(12'h100, 13'd20);
      n = 0;
      do begin
         @(negedge clk); #1; n++;
      end while (pop_n < 5 && n < 100);
      if (n >= 100) chk("pop_timeout", 0, 1);
      rst = 1;
      @(posedge clk); #1;
      exp_q.delete();
      @(negedge clk);
      chk("mid_rst_rdy", 32'(cmd_ready), 0);
      chk("mid_rst_out", 32'({m_valid, m_last, m_data, busy}), 0);
      chk("mid_rst_addr", 32'(ram_rd_addr), 0);
      @(posedge clk); #1 rst = 0;
      @(negedge clk);
      chk("after_rst_valid", 32'(m_valid), 0);
      chk("after_rst_busy", 32'(busy), 0);
      chk("after_rst_rdy", 32'(cmd_ready), 1);
      repeat (10) @(negedge clk);
      send(12'h040, 13'd8);
      wait_idle();
      chk("sb_empty", 32'(exp_q.size()), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
